// File: rtl/kf6845_pkg.sv
// Shared definitions for the KF6845 CRTC timing blocks: field widths, the
// vertical scheduler state type and the default VSYNC width.
package kf6845_pkg;

    // Character-row counter and R4/R6/R7 width.
    localparam int ROW_W = 7;
    // Raster (scan line in row) counter and R5/R9 width.
    localparam int RASTER_W = 5;
    // Total-adjust line counter width; it is compared against R5.
    localparam int ADJUST_W = 5;
    // VSYNC width counter; a width of 16 lines wraps to 0 in this field.
    localparam int VSYNC_CNT_W = 4;
    // VSYNC width in scan lines when the parent does not override it.
    localparam int VSYNC_LINES_DEFAULT = 16;

    // Vertical scheduler phase: counting character rows, or padding the
    // frame with the extra scan lines requested by R5.
    typedef enum logic {
        V_ACTIVE = 1'b0,
        V_ADJUST = 1'b1
    } vertical_state_t;

    // Count value at which VSYNC drops; 16 lines maps to 0 in a 4-bit counter.
    function automatic logic [VSYNC_CNT_W-1:0] vsync_end_count(input int lines);
        return VSYNC_CNT_W'(lines % 16);
    endfunction

endpackage

// File: rtl/kf6845_vsync_generator.sv
// VSYNC pulse generator: starts on a line advance that enters the sync row
// and holds the pulse for exactly VSYNC_LINES line advances.
module kf6845_vsync_generator
    import kf6845_pkg::*;
#(
    parameter int VSYNC_LINES = VSYNC_LINES_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic i_line_advance,
    input  logic i_start,
    output logic o_vsync
);

    localparam logic [VSYNC_CNT_W-1:0] EndCount = vsync_end_count(VSYNC_LINES);

    logic                   r_vsync;
    logic [VSYNC_CNT_W-1:0] r_count;
    logic [VSYNC_CNT_W-1:0] w_count_inc;

    assign w_count_inc = r_count + VSYNC_CNT_W'(1);

    // Pulse state: count lines while high, ignore further starts until it drops.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_vsync <= 1'b0;
            r_count <= '0;
        end else if (i_line_advance) begin
            if (r_vsync) begin
                r_count <= w_count_inc;
                if (w_count_inc == EndCount) begin
                    r_vsync <= 1'b0;
                end
            end else if (i_start) begin
                r_vsync <= 1'b1;
                r_count <= '0;
            end
        end
    end

    assign o_vsync = r_vsync;

endmodule

// File: rtl/kf6845_vertical_control.sv
// KF6845 vertical timing scheduler. Owns R4, R5, R6, R7 and R9, steps the
// raster / row counters once per scan line and produces the vertical display
// window, VSYNC and the frame start pulse.
module kf6845_vertical_control
    import kf6845_pkg::*;
#(
    parameter int VSYNC_LINES = VSYNC_LINES_DEFAULT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                video_clock_enable,
    input  logic [7:0]          internal_data_bus,
    input  logic                write_vertical_total_register,
    input  logic                write_vertical_total_adjust_register,
    input  logic                write_vertical_displayed_register,
    input  logic                write_vertical_sync_position_register,
    input  logic                write_maximum_scan_line_register,
    input  logic                Horizontal,
    input  logic                H_Display,
    output logic [RASTER_W-1:0] raster_address,
    output logic [ROW_W-1:0]    row_counter,
    output logic                V_Display,
    output logic                Display_Enable,
    output logic                VSYNC,
    output logic                Frame_Start
);

    // CRTC registers
    logic [ROW_W-1:0]    r_vertical_total;          // R4
    logic [RASTER_W-1:0] r_vertical_total_adjust;   // R5
    logic [ROW_W-1:0]    r_vertical_displayed;      // R6
    logic [ROW_W-1:0]    r_vsync_position;          // R7
    logic [RASTER_W-1:0] r_max_scan_line;           // R9

    // Scheduler state
    vertical_state_t     r_state;
    logic [RASTER_W-1:0] r_raster;
    logic [ROW_W-1:0]    r_row;
    logic [ADJUST_W-1:0] r_adjust_count;
    logic                r_v_display;
    logic                r_frame_start;

    // Next-line decode
    logic                w_line_advance;
    vertical_state_t     w_next_state;
    logic [RASTER_W-1:0] w_next_raster;
    logic [ROW_W-1:0]    w_next_row;
    logic [ADJUST_W-1:0] w_next_adjust_count;
    logic                w_new_frame;
    logic                w_adjust_done;
    logic                w_next_v_display;
    logic                w_vsync_start;
    logic                w_vsync;
    logic                w_unused_bus_msb;

    // Bit 7 of the bus is not used by any vertical register.
    assign w_unused_bus_msb = internal_data_bus[7];

    // One scan line has finished when the last character is clocked.
    assign w_line_advance = video_clock_enable & Horizontal;

    // Register file: writes land on the strobe edge regardless of the video clock enable.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_vertical_total        <= '0;
            r_vertical_total_adjust <= '0;
            r_vertical_displayed    <= '0;
            r_vsync_position        <= '0;
            r_max_scan_line         <= '0;
        end else begin
            if (write_vertical_total_register) begin
                r_vertical_total <= internal_data_bus[ROW_W-1:0];
            end
            if (write_vertical_total_adjust_register) begin
                r_vertical_total_adjust <= internal_data_bus[RASTER_W-1:0];
            end
            if (write_vertical_displayed_register) begin
                r_vertical_displayed <= internal_data_bus[ROW_W-1:0];
            end
            if (write_vertical_sync_position_register) begin
                r_vsync_position <= internal_data_bus[ROW_W-1:0];
            end
            if (write_maximum_scan_line_register) begin
                r_max_scan_line <= internal_data_bus[RASTER_W-1:0];
            end
        end
    end

    // The adjust phase lasts R5 lines; R5 rewritten to 0 mid-adjust wraps to 31.
    assign w_adjust_done = (r_adjust_count == (r_vertical_total_adjust - ADJUST_W'(1)));

    // Next-line decode: where the counters go on the coming line advance.
    always_comb begin
        w_next_state        = r_state;
        w_next_raster       = r_raster;
        w_next_row          = r_row;
        w_next_adjust_count = r_adjust_count;
        w_new_frame         = 1'b0;
        unique case (r_state)
            V_ACTIVE: begin
                if (r_raster != r_max_scan_line) begin
                    w_next_raster = r_raster + RASTER_W'(1);
                end else if (r_row != r_vertical_total) begin
                    w_next_raster = '0;
                    w_next_row    = r_row + ROW_W'(1);
                end else if (r_vertical_total_adjust == '0) begin
                    w_new_frame   = 1'b1;
                    w_next_raster = '0;
                    w_next_row    = '0;
                end else begin
                    // Row stays at R4 while the adjust lines run.
                    w_next_state        = V_ADJUST;
                    w_next_adjust_count = '0;
                    w_next_raster       = '0;
                end
            end
            V_ADJUST: begin
                if (w_adjust_done) begin
                    w_new_frame   = 1'b1;
                    w_next_state  = V_ACTIVE;
                    w_next_raster = '0;
                    w_next_row    = '0;
                end else begin
                    w_next_adjust_count = r_adjust_count + ADJUST_W'(1);
                    w_next_raster       = r_raster + RASTER_W'(1);
                end
            end
        endcase
    end

    // The window opens at a new frame and closes on entering row R6; R6 = 0 keeps it shut.
    assign w_next_v_display = (w_next_state == V_ACTIVE) &&
                              (w_next_row != r_vertical_displayed) &&
                              (r_v_display || w_new_frame);

    // Sync begins on the first scan line of row R7.
    assign w_vsync_start = (w_next_state == V_ACTIVE) &&
                           (w_next_row == r_vsync_position) &&
                           (w_next_raster == '0);

    // Vertical state machine with registered outputs; Frame_Start is a one-clock pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= V_ACTIVE;
            r_raster       <= '0;
            r_row          <= '0;
            r_adjust_count <= '0;
            r_v_display    <= 1'b0;
            r_frame_start  <= 1'b0;
        end else begin
            r_frame_start <= w_line_advance & w_new_frame;
            if (w_line_advance) begin
                r_state        <= w_next_state;
                r_raster       <= w_next_raster;
                r_row          <= w_next_row;
                r_adjust_count <= w_next_adjust_count;
                r_v_display    <= w_next_v_display;
            end
        end
    end

    kf6845_vsync_generator #(
        .VSYNC_LINES (VSYNC_LINES)
    ) u_vsync_generator (
        .clock          (clock),
        .reset          (reset),
        .i_line_advance (w_line_advance),
        .i_start        (w_vsync_start),
        .o_vsync        (w_vsync)
    );

    assign raster_address = r_raster;
    assign row_counter    = r_row;
    assign V_Display      = r_v_display;
    assign Display_Enable = H_Display & r_v_display;
    assign VSYNC          = w_vsync;
    assign Frame_Start    = r_frame_start;

endmodule

// File: tb/tb_kf6845_vertical_control.sv
// Self-checking bench for kf6845_vertical_control: a line-level reference
// model is compared against the DUT on every falling clock edge, and a few
// directed scenarios pin frame length, window and sync widths to literals.
module tb_kf6845_vertical_control;

    localparam int VL = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       video_clock_enable = 1'b0;
    logic [7:0] internal_data_bus = 8'd0;
    logic       wr4 = 1'b0;
    logic       wr5 = 1'b0;
    logic       wr6 = 1'b0;
    logic       wr7 = 1'b0;
    logic       wr9 = 1'b0;
    logic       Horizontal = 1'b0;
    logic       H_Display = 1'b0;
    logic [4:0] raster_address;
    logic [6:0] row_counter;
    logic       V_Display;
    logic       Display_Enable;
    logic       VSYNC;
    logic       Frame_Start;

    always #5 clock = ~clock;

    kf6845_vertical_control dut (
        .clock                                 (clock),
        .reset                                 (reset),
        .video_clock_enable                    (video_clock_enable),
        .internal_data_bus                     (internal_data_bus),
        .write_vertical_total_register         (wr4),
        .write_vertical_total_adjust_register  (wr5),
        .write_vertical_displayed_register     (wr6),
        .write_vertical_sync_position_register (wr7),
        .write_maximum_scan_line_register      (wr9),
        .Horizontal                            (Horizontal),
        .H_Display                             (H_Display),
        .raster_address                        (raster_address),
        .row_counter                           (row_counter),
        .V_Display                             (V_Display),
        .Display_Enable                        (Display_Enable),
        .VSYNC                                 (VSYNC),
        .Frame_Start                           (Frame_Start)
    );

    int total = 0;
    int bad = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    // Reference model: one line-advance step computed from the timing rules.
    int m_row = 0, m_ras = 0, m_adj = 0, m_vcnt = 0;
    bit m_adjusting = 0, m_vd = 0, m_vs = 0, m_fs = 0;
    int m_r4 = 0, m_r5 = 0, m_r6 = 0, m_r7 = 0, m_r9 = 0;

    always @(posedge clock or posedge reset) begin : model_proc
        int  n_row, n_ras, n_adj, vc;
        bit  n_adjusting, nf;
        if (reset) begin
            m_row = 0; m_ras = 0; m_adj = 0; m_vcnt = 0;
            m_adjusting = 0; m_vd = 0; m_vs = 0; m_fs = 0;
            m_r4 = 0; m_r5 = 0; m_r6 = 0; m_r7 = 0; m_r9 = 0;
        end else begin
            m_fs = 0;
            if (video_clock_enable && Horizontal) begin
                nf = 0; n_row = m_row; n_ras = m_ras; n_adj = m_adj;
                n_adjusting = m_adjusting;
                if (!m_adjusting) begin
                    if (m_ras != m_r9) n_ras = (m_ras + 1) % 32;
                    else if (m_row != m_r4) begin
                        n_ras = 0; n_row = (m_row + 1) % 128;
                    end else if (m_r5 == 0) begin
                        nf = 1; n_ras = 0; n_row = 0;
                    end else begin
                        n_adjusting = 1; n_adj = 0; n_ras = 0;
                    end
                end else begin
                    if (m_adj == (m_r5 + 31) % 32) begin
                        nf = 1; n_adjusting = 0; n_ras = 0; n_row = 0;
                    end else begin
                        n_adj = (m_adj + 1) % 32; n_ras = (m_ras + 1) % 32;
                    end
                end
                if (m_vs) begin
                    vc = (m_vcnt + 1) % 16;
                    m_vcnt = vc;
                    if (vc == VL % 16) m_vs = 0;
                end else if (!n_adjusting && n_row == m_r7 && n_ras == 0) begin
                    m_vs = 1; m_vcnt = 0;
                end
                m_vd = !n_adjusting && (n_row != m_r6) && (m_vd || nf);
                m_fs = nf;
                m_row = n_row; m_ras = n_ras; m_adj = n_adj; m_adjusting = n_adjusting;
            end
            if (wr4) m_r4 = int'(internal_data_bus) % 128;
            if (wr5) m_r5 = int'(internal_data_bus) % 32;
            if (wr6) m_r6 = int'(internal_data_bus) % 128;
            if (wr7) m_r7 = int'(internal_data_bus) % 128;
            if (wr9) m_r9 = int'(internal_data_bus) % 32;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clock) begin
        if (check_en) begin
            chk("raster_address", int'(raster_address), m_ras);
            chk("row_counter", int'(row_counter), m_row);
            chk("V_Display", int'(V_Display), int'(m_vd));
            chk("Display_Enable", int'(Display_Enable), int'(H_Display & m_vd));
            chk("VSYNC", int'(VSYNC), int'(m_vs));
            chk("Frame_Start", int'(Frame_Start), int'(m_fs));
        end
    end

    task automatic step(input bit vce_v, input bit hor_v, input int sel, input int data);
        @(posedge clock);
        #1;
        video_clock_enable = vce_v;
        Horizontal = hor_v;
        H_Display = 1'($urandom_range(0, 1));
        internal_data_bus = 8'(data);
        wr4 = (sel == 4); wr5 = (sel == 5); wr6 = (sel == 6);
        wr7 = (sel == 7); wr9 = (sel == 9);
        @(negedge clock);
    endtask

    task automatic tick(input bit vce_v, input bit hor_v);
        step(vce_v, hor_v, 0, 0);
    endtask

    task automatic wr(input int sel, input int data);
        step(1'b0, 1'b0, sel, data);
    endtask

    task automatic wait_frame(input int bound, input string name);
        bit found = 0;
        for (int i = 0; i < bound && !found; i++) begin
            tick(1'b1, 1'b1);
            if (Frame_Start) found = 1;
        end
        chk(name, int'(found), 1);
    endtask

    // Measure one frame starting at a Frame_Start sample.
    task automatic measure_frame(input int row_of_interest, output int len, output int nvd,
                                 output int nvs, output int nrow);
        bit done = 0;
        len = 0; nvd = 0; nvs = 0; nrow = 0;
        while (!done) begin
            len++;
            nvd += int'(V_Display);
            nvs += int'(VSYNC);
            if (int'(row_counter) == row_of_interest) nrow++;
            tick(1'b1, 1'b1);
            if (Frame_Start || len >= 3000) done = 1;
        end
    endtask

    task automatic wait_vsync(input bit lvl, input int bound, input string name);
        bit found = (VSYNC == lvl);
        for (int i = 0; i < bound && !found; i++) begin
            tick(1'b1, 1'b1);
            if (VSYNC == lvl) found = 1;
        end
        chk(name, int'(found), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, nvd, nvs, nrow, maxrow, n;
        bit found;

        // Reset state
        repeat (2) @(negedge clock);
        chk("reset_raster", int'(raster_address), 0);
        chk("reset_row", int'(row_counter), 0);
        chk("reset_vdisp", int'(V_Display), 0);
        chk("reset_vsync", int'(VSYNC), 0);
        chk("reset_fs", int'(Frame_Start), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        check_en = 1'b1;
        @(negedge clock);

        // 8 lines x 25 rows, window 20 rows, sync at row 22
        wr(9, 7); wr(4, 24); wr(5, 0); wr(6, 20); wr(7, 22);
        wait_frame(600, "s1_first_frame");
        measure_frame(24, len, nvd, nvs, nrow);
        chk("s1_frame_len", len, 200);
        chk("s1_vdisp_lines", nvd, 160);
        chk("s1_vsync_lines", nvs, 16);

        // Total adjust of 6 lines after 32 rows
        wr(4, 31); wr(5, 6);
        wait_frame(1000, "s2_first_frame");
        measure_frame(31, len, nvd, nvs, nrow);
        chk("s2_frame_len", len, 262);
        chk("s2_row31_lines", nrow, 14);

        // Gating: either enable term low alone must not advance
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b1);
        wr(6, 20);

        // Mid-frame reset with VSYNC high at row 10 raster 3
        wr(7, 10);
        found = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            tick(1'b1, 1'b1);
            if (m_row == 10 && m_ras == 3 && m_vs) found = 1;
        end
        chk("s4_reached_row10", int'(found), 1);
        chk("s4_vsync_before_reset", int'(VSYNC), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("s4_async_raster", int'(raster_address), 0);
        chk("s4_async_row", int'(row_counter), 0);
        chk("s4_async_vdisp", int'(V_Display), 0);
        chk("s4_async_vsync", int'(VSYNC), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        tick(1'b1, 1'b1);
        chk("s4_first_la_fs", int'(Frame_Start), 1);
        chk("s4_first_la_vsync", int'(VSYNC), 1);
        tick(1'b1, 1'b1);
        chk("s4_second_la_fs", int'(Frame_Start), 1);

        // Sync spanning the frame wrap: 12-line frame, sync at row 5
        wr(9, 1); wr(4, 5); wr(5, 0); wr(7, 5); wr(6, 3);
        wait_vsync(1'b0, 100, "s5_wait_low0");
        wait_vsync(1'b1, 100, "s5_wait_high0");
        wait_vsync(1'b0, 100, "s5_wait_low1");
        wait_vsync(1'b1, 100, "s5_wait_high1");
        n = 0;
        while (VSYNC && n < 100) begin n++; tick(1'b1, 1'b1); end
        chk("s5_vsync_high_len", n, 16);
        n = 0;
        while (!VSYNC && n < 100) begin n++; tick(1'b1, 1'b1); end
        chk("s5_vsync_low_len", n, 8);

        // Shrink R4 below the current row: the row counter wraps through 127
        wr(9, 7); wr(4, 24); wr(6, 20); wr(7, 22);
        found = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            tick(1'b1, 1'b1);
            if (m_row == 10) found = 1;
        end
        chk("s6_reached_row10", int'(found), 1);
        wr(4, 3);
        maxrow = 0;
        found = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            tick(1'b1, 1'b1);
            if (int'(row_counter) > maxrow) maxrow = int'(row_counter);
            if (Frame_Start) found = 1;
        end
        chk("s6_wrap_frame", int'(found), 1);
        chk("s6_max_row", maxrow, 127);
        measure_frame(3, len, nvd, nvs, nrow);
        chk("s6_frame_len", len, 32);

        // Randomised enables, display window and register writes
        for (int i = 0; i < 4000; i++) begin
            @(posedge clock);
            #1;
            video_clock_enable = ($urandom_range(0, 3) != 0);
            Horizontal = ($urandom_range(0, 2) == 0);
            H_Display = 1'($urandom_range(0, 1));
            internal_data_bus = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                                            : 8'($urandom_range(0, 15));
            wr4 = ($urandom_range(0, 31) == 0);
            wr5 = ($urandom_range(0, 31) == 0);
            wr6 = ($urandom_range(0, 31) == 0);
            wr7 = ($urandom_range(0, 31) == 0);
            wr9 = ($urandom_range(0, 31) == 0);
        end
        tick(1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
